// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave terminating single transfers on a single-port synchronous SRAM.
// Decodes lanes/alignment, adds WAIT_STATES wait cycles, returns OKAY or two-cycle ERROR.
module ahb_sram_slave #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [2:0]                hburst_i,
  input  logic [3:0]                hprot_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hmastlock_i,
  input  logic                      hready_i,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      hreadyout_o,
  output logic                      hresp_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                    state_q, state_d, disp_c;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      we_q;
  logic [3:0]                be_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic                      acc_c, take_c, err_c;
  logic [3:0]                be_c;
  logic                      unused_inputs;

  assign acc_c = hsel_i & htrans_i[1] & hready_i;

  // Lane decode and natural-alignment check of the current address phase
  always_comb begin
    be_c  = 4'b0000;
    err_c = 1'b0;
    case (hsize_i)
      3'b000: be_c = 4'b0001 << haddr_i[1:0];
      3'b001: begin
        be_c  = 4'b0011 << {haddr_i[1], 1'b0};
        err_c = haddr_i[0];
      end
      3'b010: begin
        be_c  = 4'b1111;
        err_c = |haddr_i[1:0];
      end
      default: err_c = 1'b1;
    endcase
  end

  // Where an accepted address phase goes next
  always_comb begin
    if (err_c)                 disp_c = S_ERR1;
    else if (WAIT_STATES > 0)  disp_c = S_WAIT;
    else if (!hwrite_i)        disp_c = S_RD;
    else                       disp_c = S_DATA;
  end

  // Next-state and bus/SRAM outputs, all decoded from the registered state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    take_c      = 1'b0;
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    hrdata_o    = '0;
    case (state_q)
      S_WAIT: begin
        hreadyout_o = 1'b0;
        if (cnt_q == '0) begin
          state_d = we_q ? S_DATA : S_RD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RD: begin
        hreadyout_o = 1'b0;
        mem_req_o   = 1'b1;
        state_d     = S_DATA;
      end
      S_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
        state_d     = S_ERR2;
      end
      default: begin
        if (state_q == S_ERR2) hresp_o = 1'b1;
        if (state_q == S_DATA) begin
          mem_req_o = we_q;
          mem_we_o  = we_q;
          if (!we_q) hrdata_o = AHB_DATA_WIDTH'(mem_rdata_i);
        end
        if (acc_c) begin
          take_c  = 1'b1;
          state_d = disp_c;
          if (disp_c == S_WAIT) cnt_d = CNT_W'(WAIT_STATES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_c) begin
        we_q   <= hwrite_i;
        be_q   <= be_c;
        addr_q <= haddr_i[MEM_ADDR_WIDTH+1:2];
      end
    end
  end

  // Reads always use the registered address, so SRAM sees at most one access per cycle
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = 32'(hwdata_i);

  assign unused_inputs = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0], haddr_i};

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave that terminates transfers from the RI5CY-to-AHB master bridge on a single-port synchronous SRAM macro. It decodes address-phase control into SRAM byte enables and word addresses. It also inserts a configurable number of wait states, issues one SRAM access per transfer, and returns OKAY or the two-cycle ERROR response. It sits directly downstream of the core's AHB master port, with one master and one slave; `hready_i` is normally tied to this block's `hreadyout_o`.

## Interface
Parameters:
- AHB_ADDR_WIDTH, 32, width of `haddr_i`.
- AHB_DATA_WIDTH, 32, data width. Only 32 is supported.
- MEM_ADDR_WIDTH, 10, SRAM word-address width (4 KiB default).
- WAIT_STATES, 0, extra data-phase wait cycles per transfer, 0..7.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rstn  in  1  synchronous, active-low reset.
- hsel_i  in  1  slave select.
- haddr_i  in  AHB_ADDR_WIDTH  byte address; only bits [MEM_ADDR_WIDTH+1:0] are used, upper bits are ignored.
- hwdata_i  in  AHB_DATA_WIDTH  write data, valid in the data phase.
- hwrite_i  in  1  1 = write.
- hsize_i  in  3  transfer size.
- hburst_i  in  3  ignored; only single transfers are handled.
- hprot_i  in  4  ignored.
- htrans_i  in  2  transfer type.
- hmastlock_i  in  1  ignored.
- hready_i  in  1  bus ready; qualifies the address phase.
- hrdata_o  out  AHB_DATA_WIDTH  read data.
- hreadyout_o  out  1  slave ready.
- hresp_o  out  1  1 = ERROR.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  4  SRAM byte enables.
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM word address.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data, valid one cycle after a read strobe.

## Operation
- **Accept condition:** `acc = hsel_i & htrans_i[1] & hready_i` (NONSEQ or SEQ). On `acc`, register `we`, word address `haddr_i[MEM_ADDR_WIDTH+1:2]`, byte enables and the error flag.
- **Non-accepted cycles:** IDLE or BUSY transfers, or `hsel_i` low, get a zero-wait OKAY and cause no state change.
- **Byte enables:**
  - BYTE (000): `4'b0001 << haddr[1:0]`.
  - HALFWORD (001): `4'b0011 << {haddr[1],1'b0}`.
  - WORD (010): `4'b1111`.
- **Error transfers:** any of the following produces an ERROR response and no SRAM access:
  - `hsize_i` > 010;
  - HALFWORD with `haddr[0]` = 1;
  - WORD with `haddr[1:0]` != 0.
- **FSM states:** IDLE, WAIT, RD, DATA, ERR1, ERR2.
  - IDLE: `hreadyout_o`=1, `hresp_o`=0. On `acc`, take the next state per the dispatch rule below; otherwise stay in IDLE.
  - WAIT: `hreadyout_o`=0. `cnt` decrements each cycle. When `cnt`==0, go to RD for a read or DATA for a write.
  - RD: `hreadyout_o`=0. Drive `mem_req_o`=1, `mem_we_o`=0 and the registered address. Go to DATA.
  - DATA: `hreadyout_o`=1.
    - Write: `mem_req_o`=1, `mem_we_o`=1, `mem_be_o`=registered BEs, `mem_wdata_o`=`hwdata_i`.
    - Read: `hrdata_o`=`mem_rdata_i`.
    - Next state: dispatch on `acc` (pipelined back-to-back transfer), else IDLE.
  - ERR1: `hreadyout_o`=0, `hresp_o`=1. Go to ERR2.
  - ERR2: `hreadyout_o`=1, `hresp_o`=1. Next state: dispatch on `acc`, else IDLE.
- **Dispatch rule:**
  - error flag set → ERR1;
  - else WAIT_STATES>0 → WAIT with `cnt`=WAIT_STATES-1;
  - else read → RD;
  - else write → DATA.
- **Single-port discipline:** the SRAM never sees more than one access per cycle. Reads are always issued from the registered address, so a read's address phase overlapping a write's DATA cycle cannot conflict.
- **Idle outputs:** `hrdata_o` = 0 outside a read DATA cycle. `mem_be_o`, `mem_addr_o` and `mem_wdata_o` are don't-care when `mem_req_o`=0.

## Timing
- **Reset values:** `hreadyout_o`=1, `hresp_o`=0, `hrdata_o`=0, `mem_req_o`=0, `mem_we_o`=0, FSM = IDLE, `cnt`=0.
- **Write latency:** address phase in cycle N; DATA (completion) in cycle N+1+W, where W = WAIT_STATES. The SRAM write happens on that cycle's clock edge.
- **Read latency:** address phase N; RD in N+1+W; DATA in N+2+W, with `hrdata_o` valid in that cycle. A read therefore always has W+1 wait cycles.
- **Error latency:** address phase N; ERR1 in N+1; ERR2 in N+2. WAIT_STATES does not apply.
- **Back-to-back:** an address phase accepted during DATA or ERR2 starts the next transfer with no idle cycle.
- **Address-phase gating:** while `hreadyout_o`=0, `hready_i` is low, so no new address phase is accepted.
- **Reset mid-transfer:** the FSM returns to IDLE on the next edge. A pending SRAM write is dropped and `mem_req_o` is low from that edge on.

## Test plan
- **Word write then read, W=0:** WORD write 0xDEADBEEF to 0x10 completes with zero wait and `mem_be_o`=1111, `mem_addr_o`=4. Read of 0x10 then shows `hreadyout_o` low for 1 cycle and returns 0xDEADBEEF with OKAY.
- **Byte and halfword lanes:** BYTE write 0xAA to 0x13 gives `mem_be_o`=1000. HALFWORD write to 0x16 gives `mem_be_o`=1100. Reading 0x14 then returns the merged word.
- **Misaligned WORD:** WORD access to 0x02 → `hresp_o`=1 with `hreadyout_o`=0 for one cycle, then `hresp_o`=1 with `hreadyout_o`=1. `mem_req_o` never asserts.
- **WAIT_STATES=2:** write shows 2 wait cycles; read shows 3 wait cycles. The data in both directions is correct.
- **Pipelined traffic:** write 0x20 immediately followed by read 0x20 (read address phase during the write's DATA cycle) → no SRAM double access, and the read returns the new data.
- **Reset mid-transfer:** `rstn` low during WAIT → next cycle `hreadyout_o`=1, `hresp_o`=0, `mem_req_o`=0, and the target word is unchanged.
